// File: rtl/aibcr3_rambit_cfg_ctrl.sv
// Serial config sequencer for the aibcr3 rambit chain.
// Ports: wr_* word in, rd_* old chain out, scan_* chain I/F, busy, power pins.
module aibcr3_rambit_cfg_ctrl #(
  parameter int NBITS     = 32,
  parameter int SHIFT_DIV = 1
) (
  input  logic             cfg_avmm_clk,
  input  logic             cfg_avmm_rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [NBITS-1:0] wr_data,
  output logic             rd_valid,
  output logic [NBITS-1:0] rd_data,
  output logic             scan_en,
  output logic             scan_din,
  input  logic             scan_dout,
  output logic             scan_upd,
  output logic             busy,
  input  logic             vcc,
  input  logic             vssl
);

  localparam int CW = $clog2(NBITS + 1);
  localparam int DW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SHIFT_DIV - 1);
  localparam logic [CW-1:0] LAST    = CW'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE, SHIFT, UPDATE, DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [NBITS-1:0] sreg;
  logic [CW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic             accept;
  logic             tick;
  logic             unused_pwr;

  assign unused_pwr = vcc ^ vssl;

  assign accept = wr_valid & wr_ready;
  assign tick   = (state == SHIFT) && (div_cnt == DIV_MAX);

  always_ff @(posedge cfg_avmm_clk or negedge cfg_avmm_rst_n) begin
    if (!cfg_avmm_rst_n) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (accept) state_nxt = SHIFT;
      SHIFT:  if (tick && bit_cnt == LAST) state_nxt = UPDATE;
      UPDATE: state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_ready = 1'b0;
    scan_en  = 1'b0;
    scan_upd = 1'b0;
    rd_valid = 1'b0;
    unique case (state)
      IDLE:   wr_ready = 1'b1;
      SHIFT:  scan_en  = tick;
      UPDATE: scan_upd = 1'b1;
      DONE:   rd_valid = 1'b1;
      default: wr_ready = 1'b0;
    endcase
  end

  assign busy     = (state != IDLE);
  assign scan_din = sreg[0];

  // Chain tail enters at the MSB so that after NBITS ticks sreg holds
  // the previous chain contents in word order.
  always_ff @(posedge cfg_avmm_clk or negedge cfg_avmm_rst_n) begin
    if (!cfg_avmm_rst_n) begin
      sreg    <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      rd_data <= '0;
    end else begin
      if (accept) begin
        sreg    <= wr_data;
        bit_cnt <= '0;
        div_cnt <= '0;
      end else if (state == SHIFT) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          sreg    <= {scan_dout, sreg[NBITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (state == UPDATE) rd_data <= sreg;
    end
  end

endmodule

// File: tb/tb_aibcr3_rambit_cfg_ctrl.sv
// Directed bench for aibcr3_rambit_cfg_ctrl.
// Two instances (SHIFT_DIV 1 and 3) each drive a behavioural rambit chain.
module tb_aibcr3_rambit_cfg_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cmp = 0;
  int err = 0;

  logic       wv1 = 0, wr1, rv1, se1, sdi1, su1, b1;
  logic [7:0] wd1 = 0, rd1;
  logic       wv3 = 0, wr3, rv3, se3, sdi3, su3, b3;
  logic [7:0] wd3 = 0, rd3;

  logic [7:0] ch1 = 0, rb1 = 0, ldv1 = 0;
  logic [7:0] ch3 = 0, rb3 = 0, ldv3 = 0;
  logic       ld1 = 0, ld3 = 0;

  aibcr3_rambit_cfg_ctrl #(.NBITS(8), .SHIFT_DIV(1)) u1 (
    .cfg_avmm_clk(clk), .cfg_avmm_rst_n(rst_n),
    .wr_valid(wv1), .wr_ready(wr1), .wr_data(wd1),
    .rd_valid(rv1), .rd_data(rd1),
    .scan_en(se1), .scan_din(sdi1), .scan_dout(ch1[0]),
    .scan_upd(su1), .busy(b1), .vcc(1'b1), .vssl(1'b0)
  );

  aibcr3_rambit_cfg_ctrl #(.NBITS(8), .SHIFT_DIV(3)) u3 (
    .cfg_avmm_clk(clk), .cfg_avmm_rst_n(rst_n),
    .wr_valid(wv3), .wr_ready(wr3), .wr_data(wd3),
    .rd_valid(rv3), .rd_data(rd3),
    .scan_en(se3), .scan_din(sdi3), .scan_dout(ch3[0]),
    .scan_upd(su3), .busy(b3), .vcc(1'b1), .vssl(1'b0)
  );

  // Rambit chain models: head at bit 7, tail at bit 0.
  always @(posedge clk) begin
    if (ld1) ch1 <= ldv1;
    else if (se1) ch1 <= {sdi1, ch1[7:1]};
    if (su1) rb1 <= ch1;
    if (ld3) ch3 <= ldv3;
    else if (se3) ch3 <= {sdi3, ch3[7:1]};
    if (su3) rb3 <= ch3;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    cmp++; if (wr1 !== 1'b1) begin err++; $display("FAIL rst_wr_ready got %b want 1", wr1); end
    cmp++; if (b1 !== 1'b0) begin err++; $display("FAIL rst_busy got %b want 0", b1); end
    cmp++; if (se1 !== 1'b0) begin err++; $display("FAIL rst_scan_en got %b want 0", se1); end
    cmp++; if (su1 !== 1'b0) begin err++; $display("FAIL rst_scan_upd got %b want 0", su1); end
    cmp++; if (rv1 !== 1'b0) begin err++; $display("FAIL rst_rd_valid got %b want 0", rv1); end
    cmp++; if (sdi1 !== 1'b0) begin err++; $display("FAIL rst_scan_din got %b want 0", sdi1); end
    cmp++; if (rd1 !== 8'h00) begin err++; $display("FAIL rst_rd_data got %h want 00", rd1); end
    rst_n = 1'b1;
    step();
    cmp++; if (wr1 !== 1'b1 || b1 !== 1'b0) begin
      err++; $display("FAIL rel_idle got rdy=%b busy=%b want 1/0", wr1, b1);
    end
  endtask

  task automatic test_basic();
    logic [7:0] w = 8'hA5;
    ld1 = 1; ldv1 = 8'h3C;
    step();
    ld1 = 0;
    wv1 = 1; wd1 = w;
    step();
    wv1 = 0; wd1 = 8'h00;
    for (int c = 1; c <= 11; c++) begin
      cmp++; if (se1 !== (c <= 8)) begin
        err++; $display("FAIL basic_en c%0d got %b want %b", c, se1, c <= 8);
      end
      if (c <= 8) begin
        cmp++; if (sdi1 !== w[c-1]) begin
          err++; $display("FAIL basic_din c%0d got %b want %b", c, sdi1, w[c-1]);
        end
      end
      cmp++; if (su1 !== (c == 9)) begin
        err++; $display("FAIL basic_upd c%0d got %b want %b", c, su1, c == 9);
      end
      cmp++; if (rv1 !== (c == 10)) begin
        err++; $display("FAIL basic_rv c%0d got %b want %b", c, rv1, c == 10);
      end
      cmp++; if (wr1 !== (c == 11) || b1 !== (c <= 10)) begin
        err++; $display("FAIL basic_rdy c%0d got rdy=%b busy=%b", c, wr1, b1);
      end
      if (c == 10) begin
        cmp++; if (rd1 !== 8'h3C) begin err++; $display("FAIL basic_rd got %h want 3c", rd1); end
        cmp++; if (rb1 !== 8'hA5) begin err++; $display("FAIL basic_rb got %h want a5", rb1); end
      end
      step();
    end
  endtask

  task automatic test_div3();
    ld3 = 1; ldv3 = 8'h96;
    step();
    ld3 = 0;
    wv3 = 1; wd3 = 8'hFF;
    step();
    wv3 = 0; wd3 = 8'h00;
    for (int c = 1; c <= 27; c++) begin
      cmp++; if (se3 !== (c % 3 == 0 && c <= 24)) begin
        err++; $display("FAIL div3_en c%0d got %b", c, se3);
      end
      if (c <= 24) begin
        cmp++; if (sdi3 !== 1'b1) begin err++; $display("FAIL div3_din c%0d got %b want 1", c, sdi3); end
      end
      cmp++; if (su3 !== (c == 25) || rv3 !== (c == 26)) begin
        err++; $display("FAIL div3_upd_rv c%0d got upd=%b rv=%b", c, su3, rv3);
      end
      cmp++; if (wr3 !== (c == 27)) begin
        err++; $display("FAIL div3_rdy c%0d got %b want %b", c, wr3, c == 27);
      end
      if (c == 26) begin
        cmp++; if (rd3 !== 8'h96) begin err++; $display("FAIL div3_rd got %h want 96", rd3); end
        cmp++; if (rb3 !== 8'hFF) begin err++; $display("FAIL div3_rb got %h want ff", rb3); end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w2 = 8'h22;
    wv1 = 1; wd1 = 8'h11;
    step();
    wd1 = w2;
    for (int c = 1; c <= 21; c++) begin
      if (c == 12) wv1 = 0;
      cmp++; if (se1 !== ((c <= 8) || (c >= 12 && c <= 19))) begin
        err++; $display("FAIL b2b_en c%0d got %b", c, se1);
      end
      if (c >= 12 && c <= 19) begin
        cmp++; if (sdi1 !== w2[c-12]) begin
          err++; $display("FAIL b2b_din c%0d got %b want %b", c, sdi1, w2[c-12]);
        end
      end
      cmp++; if (wr1 !== (c == 11)) begin
        err++; $display("FAIL b2b_rdy c%0d got %b want %b", c, wr1, c == 11);
      end
      cmp++; if (rv1 !== (c == 10 || c == 21)) begin
        err++; $display("FAIL b2b_rv c%0d got %b", c, rv1);
      end
      if (c == 10) begin
        cmp++; if (rd1 !== 8'hA5) begin err++; $display("FAIL b2b_rd1 got %h want a5", rd1); end
      end
      if (c == 21) begin
        cmp++; if (rd1 !== 8'h11) begin err++; $display("FAIL b2b_rd2 got %h want 11", rd1); end
        cmp++; if (rb1 !== 8'h22) begin err++; $display("FAIL b2b_rb got %h want 22", rb1); end
      end
      step();
    end
  endtask

  task automatic test_abort();
    logic [7:0] pre;
    wv1 = 1; wd1 = 8'hC3;
    step();
    wv1 = 0;
    step();
    step();
    step();
    cmp++; if (se1 !== 1'b1) begin err++; $display("FAIL abort_pre_en got %b want 1", se1); end
    rst_n = 1'b0;
    #1;
    cmp++; if (se1 !== 1'b0 || b1 !== 1'b0 || wr1 !== 1'b1) begin
      err++; $display("FAIL abort_async got en=%b busy=%b rdy=%b", se1, b1, wr1);
    end
    cmp++; if (sdi1 !== 1'b0 || rd1 !== 8'h00) begin
      err++; $display("FAIL abort_regs got din=%b rd=%h", sdi1, rd1);
    end
    pre = ch1;
    for (int c = 0; c < 3; c++) begin
      step();
      cmp++; if (su1 !== 1'b0 || rv1 !== 1'b0 || se1 !== 1'b0) begin
        err++; $display("FAIL abort_quiet c%0d got upd=%b rv=%b en=%b", c, su1, rv1, se1);
      end
    end
    cmp++; if (rb1 !== 8'h22) begin err++; $display("FAIL abort_rb got %h want 22", rb1); end
    rst_n = 1'b1;
    step();
    wv1 = 1; wd1 = 8'h5A;
    step();
    wv1 = 0;
    for (int c = 1; c <= 11; c++) begin
      if (c == 10) begin
        cmp++; if (rv1 !== 1'b1 || rd1 !== pre) begin
          err++; $display("FAIL abort_rd got rv=%b rd=%h want 1/%h", rv1, rd1, pre);
        end
        cmp++; if (rb1 !== 8'h5A) begin err++; $display("FAIL abort_rb2 got %h want 5a", rb1); end
      end
      step();
    end
    cmp++; if (wr1 !== 1'b1) begin err++; $display("FAIL abort_idle got %b want 1", wr1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div3();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
